// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide issue controller: op codes,
// the idle drive value and the occupancy state encoding.
package md_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MFHI  = 3'b110;
  localparam logic [2:0] OP_MFLO  = 3'b111;

  // Falls into the unit's default branch, so an idle unit never writes hi/lo.
  localparam logic [2:0] OP_NOP   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_sched.sv
// Issue and hazard controller for the P6 multiply/divide unit: decodes the
// E-stage md op, drives Start/md_op and stalls D-stage md ops while busy.
module md_sched
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_md_valid,
  input  logic        ex_md_valid,
  input  logic [2:0]  ex_md_op,
  input  logic        ex_kill,
  output logic        md_start,
  output logic [2:0]  md_op,
  output logic        rd_hi,
  output logic        stall,
  output logic        busy,
  output logic        proto_err,
  output logic [15:0] stall_cnt,
  output logic [1:0]  dbg_state
);

  md_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_proto_err;
  logic [15:0]      r_stall_cnt;

  logic w_go;
  logic w_issue;
  logic w_mt;
  logic w_bad;

  // Handshake: md_start is a one-cycle strobe qualified by md_op. The unit
  // offers no ready; occupancy is inferred from the local latency counter,
  // so MULT_CYCLES/DIV_CYCLES must match the unit exactly.
  assign w_go    = ex_md_valid & ~ex_kill;
  assign w_issue = w_go & ~ex_md_op[2] & (r_state == IDLE);
  assign w_mt    = w_go & (ex_md_op[2:1] == 2'b10) & (r_state == IDLE);
  assign w_bad   = w_go & (ex_md_op[2:1] != 2'b11) & (r_state != IDLE);

  assign md_start  = w_issue;
  assign md_op     = (w_issue | w_mt) ? ex_md_op : OP_NOP;
  assign rd_hi     = (ex_md_op == OP_MFHI);
  assign busy      = w_issue | (r_state != IDLE);
  assign stall     = id_md_valid & busy;
  assign proto_err = r_proto_err;
  assign stall_cnt = r_stall_cnt;
  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_proto_err <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            if (ex_md_op[1]) begin
              r_state <= DIV;
              r_cnt   <= CNT_W'(DIV_CYCLES);
            end else begin
              r_state <= MUL;
              r_cnt   <= CNT_W'(MULT_CYCLES);
            end
          end
        end
        MUL, DIV: begin
          // The unit cannot abort, so the count always runs to completion.
          if (r_cnt == CNT_W'(1)) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase

      if (w_bad) r_proto_err <= 1'b1;
      if (stall && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Bench for md_sched with a behavioural md unit attached: directed E/D-stage
// vectors push expected outputs; a negedge monitor pops and compares.
module tb_md_sched;
  import md_pkg::*;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        id_md_valid = 1'b0;
  logic        ex_md_valid = 1'b0;
  logic [2:0]  ex_md_op    = 3'b000;
  logic        ex_kill     = 1'b0;
  logic [31:0] ex_a        = '0;
  logic [31:0] ex_b        = '0;
  logic        md_start;
  logic [2:0]  md_op;
  logic        rd_hi;
  logic        stall;
  logic        busy;
  logic        proto_err;
  logic [15:0] stall_cnt;
  logic [1:0]  dbg_state;

  md_sched #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .id_md_valid(id_md_valid), .ex_md_valid(ex_md_valid),
    .ex_md_op(ex_md_op), .ex_kill(ex_kill), .md_start(md_start), .md_op(md_op),
    .rd_hi(rd_hi), .stall(stall), .busy(busy), .proto_err(proto_err),
    .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  // behavioural md unit, reset by the same signal
  logic [31:0] u_hi, u_lo, u_phi, u_plo;
  logic [3:0]  u_cnt;

  function automatic logic [63:0] md_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0]        up;
    case (op)
      OP_MULT:  begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp; end
      OP_MULTU: begin up = {32'd0, a} * {32'd0, b}; return up; end
      OP_DIV:   return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      default:  return {a % b, a / b};
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      u_hi <= '0; u_lo <= '0; u_phi <= '0; u_plo <= '0; u_cnt <= '0;
    end else begin
      if (md_start) begin
        u_cnt <= md_op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        {u_phi, u_plo} <= md_calc(md_op, ex_a, ex_b);
      end else if (u_cnt != 4'd0) begin
        u_cnt <= u_cnt - 4'd1;
        if (u_cnt == 4'd1) begin
          u_hi <= u_phi;
          u_lo <= u_plo;
        end
      end
      if (md_op == OP_MTHI) u_hi <= ex_a;
      if (md_op == OP_MTLO) u_lo <= ex_a;
    end
  end

  // scoreboard: {state, start, op, rd_hi, stall, busy, proto_err, stall_cnt}
  localparam int W = 26;
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  logic [15:0]  sc = '0;

  function automatic logic [W-1:0] ev(input logic [1:0] st, input logic s, input logic [2:0] op,
                                      input logic rh, input logic stl, input logic bz, input logic pe);
    return {st, s, op, rh, stl, bz, pe, sc};
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {dbg_state, md_start, md_op, rd_hi, stall, busy, proto_err, stall_cnt};
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL %s: got st=%0d start=%b op=%b rd_hi=%b stall=%b busy=%b perr=%b scnt=%0d, expected st=%0d start=%b op=%b rd_hi=%b stall=%b busy=%b perr=%b scnt=%0d",
                 nm, a[25:24], a[23], a[22:20], a[19], a[18], a[17], a[16], a[15:0],
                 e[25:24], e[23], e[22:20], e[19], e[18], e[17], e[16], e[15:0]);
      end
    end
  end

  // driver: called at posedge+1, holds inputs for one cycle
  task automatic drive(input string nm, input logic idv, input logic exv, input logic [2:0] op,
                       input logic kill, input logic [W-1:0] e);
    id_md_valid = idv;
    ex_md_valid = exv;
    ex_md_op    = op;
    ex_kill     = kill;
    exp_q.push_back(e);
    name_q.push_back(nm);
    if (e[18]) sc = (sc == 16'hFFFF) ? sc : sc + 16'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  initial begin
    // reset held low for three cycles
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive("reset", 0, 0, 3'b000, 0, ev(2'd0, 0, 3'b111, 0, 0, 0, 0));
    reset = 1'b1;

    // mult 0x7FFFFFFF*2 with mflo waiting in D
    ex_a = 32'h7FFF_FFFF; ex_b = 32'd2;
    drive("mul_issue", 1, 1, OP_MULT, 0, ev(2'd0, 1, 3'b000, 0, 1, 1, 0));
    for (int i = 0; i < 5; i++)
      drive("mul_wait", 1, 0, 3'b000, 0, ev(2'd1, 0, 3'b111, 0, 1, 1, 0));
    drive("mul_done", 1, 0, 3'b000, 0, ev(2'd0, 0, 3'b111, 0, 0, 0, 0));
    drive("mflo_in_e", 0, 1, OP_MFLO, 0, ev(2'd0, 0, 3'b111, 0, 0, 0, 0));
    check32("mul_lo", u_lo, 32'hFFFF_FFFE);
    check32("mul_hi", u_hi, 32'h0000_0000);

    // div 100/7 with mfhi waiting in D
    ex_a = 32'd100; ex_b = 32'd7;
    drive("div_issue", 1, 1, OP_DIV, 0, ev(2'd0, 1, 3'b010, 0, 1, 1, 0));
    for (int i = 0; i < 10; i++)
      drive("div_wait", 1, 0, 3'b000, 0, ev(2'd2, 0, 3'b111, 0, 1, 1, 0));
    drive("div_done", 1, 0, 3'b000, 0, ev(2'd0, 0, 3'b111, 0, 0, 0, 0));
    drive("mfhi_in_e", 0, 1, OP_MFHI, 0, ev(2'd0, 0, 3'b111, 1, 0, 0, 0));
    check32("div_hi", u_hi, 32'd2);
    check32("div_lo", u_lo, 32'd14);

    // killed div: nothing issues, nothing stalls
    ex_a = 32'd55; ex_b = 32'd3;
    drive("div_kill", 1, 1, OP_DIV, 1, ev(2'd0, 0, 3'b111, 0, 0, 0, 0));
    drive("after_kill", 1, 0, 3'b000, 0, ev(2'd0, 0, 3'b111, 0, 0, 0, 0));
    repeat (11) begin @(posedge clk); #1; end
    check32("kill_hi", u_hi, 32'd2);
    check32("kill_lo", u_lo, 32'd14);

    // mthi while idle
    ex_a = 32'h0000_1234;
    drive("mthi", 0, 1, OP_MTHI, 0, ev(2'd0, 0, 3'b100, 0, 0, 0, 0));
    drive("mthi_after", 0, 0, 3'b000, 0, ev(2'd0, 0, 3'b111, 0, 0, 0, 0));
    check32("mthi_hi", u_hi, 32'h0000_1234);
    check32("mthi_lo", u_lo, 32'd14);

    // mult forced into E two cycles after a div issue
    ex_a = 32'd50; ex_b = 32'd5;
    drive("div2_issue", 0, 1, OP_DIV, 0, ev(2'd0, 1, 3'b010, 0, 0, 1, 0));
    drive("div2_t1", 0, 0, 3'b000, 0, ev(2'd2, 0, 3'b111, 0, 0, 1, 0));
    drive("bad_mult", 0, 1, OP_MULT, 0, ev(2'd2, 0, 3'b111, 0, 0, 1, 0));
    for (int i = 0; i < 8; i++)
      drive("perr_sticky", 0, 0, 3'b000, 0, ev(2'd2, 0, 3'b111, 0, 0, 1, 1));
    drive("div2_done", 0, 0, 3'b000, 0, ev(2'd0, 0, 3'b111, 0, 0, 0, 1));
    drive("perr_idle", 0, 0, 3'b000, 0, ev(2'd0, 0, 3'b111, 0, 0, 0, 1));
    check32("div2_lo", u_lo, 32'd10);
    check32("div2_hi", u_hi, 32'd0);

    // asynchronous reset three cycles into a divide
    ex_a = 32'd9; ex_b = 32'd2;
    drive("div3_issue", 0, 1, OP_DIV, 0, ev(2'd0, 1, 3'b010, 0, 0, 1, 1));
    drive("div3_t1", 0, 0, 3'b000, 0, ev(2'd2, 0, 3'b111, 0, 0, 1, 1));
    drive("div3_t2", 0, 0, 3'b000, 0, ev(2'd2, 0, 3'b111, 0, 0, 1, 1));
    reset = 1'b0;
    sc = '0;
    drive("async_rst", 0, 0, 3'b000, 0, ev(2'd0, 0, 3'b111, 0, 0, 0, 0));
    reset = 1'b1;
    drive("post_rst", 1, 0, 3'b000, 0, ev(2'd0, 0, 3'b111, 0, 0, 0, 0));
    check32("rst_hi", u_hi, 32'd0);
    check32("rst_lo", u_lo, 32'd0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end
    #2;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Issue and hazard controller for the multiply/divide unit in the P6 five-stage pipeline.
- Decodes the E-stage mult/div/mthi/mtlo/mfhi/mflo class and drives the unit's Start and md_op.
- Tracks the unit's occupancy with its own latency counter and raises the D-stage stall for any md-class instruction behind a busy unit.
- Sits between the E-stage pipeline register and the md unit; stall ORs into the hazard unit.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu issue edge; must equal the unit's multiply count.
- DIV_CYCLES, 10, busy cycles after a div/divu issue edge; must equal the unit's divide count.
- CNT_W, 4, counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset.
- id_md_valid  in  1  D-stage instruction is md-class (any of the 8 ops).
- ex_md_valid  in  1  E-stage instruction is md-class.
- ex_md_op  in  3  E-stage op: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 mfhi, 111 mflo.
- ex_kill  in  1  E-stage instruction is cancelled this cycle (exception/flush).
- md_start  out  1  Start to the md unit.
- md_op  out  3  op to the md unit.
- rd_hi  out  1  E-stage result mux select: 1 = hi, 0 = lo.
- stall  out  1  freeze PC/F/D, bubble into E.
- busy  out  1  unit occupied this cycle.
- proto_err  out  1  sticky flag for an illegal E-stage issue while busy.
- stall_cnt  out  16  saturating count of cycles with stall=1.

Behaviour:
- Reset: state=IDLE, cnt=0, proto_err=0, stall_cnt=0. All outputs read 0, except md_op=111, which falls to the unit's no-op default branch.
- Definitions:
  - go = ex_md_valid & ~ex_kill.
  - issue = go & ~ex_md_op[2] & (state==IDLE).
  - mt = go & (ex_md_op[2:1]==2'b10) & (state==IDLE).
- Outputs, all combinational:
  - md_start = issue.
  - md_op = ex_md_op when issue or mt; otherwise 111. md_op is never left at 100/101 when idle, so hi/lo cannot be written spuriously.
  - rd_hi = (ex_md_op==110).
  - busy = issue | (state!=IDLE).
  - stall = id_md_valid & busy.
- States: IDLE, MUL, DIV.
  - IDLE→MUL on issue with op 00x; cnt←MULT_CYCLES.
  - IDLE→DIV on issue with op 01x; cnt←DIV_CYCLES.
  - In MUL or DIV: cnt decrements each cycle; state returns to IDLE on the edge where cnt==1 (cnt←0).
- Latency: a mult issued at edge T keeps busy=1 from the issue cycle through cycle T+MULT_CYCLES; the first non-stalled md instruction leaves D at T+MULT_CYCLES+1. Divide is the same with DIV_CYCLES.
- Boundaries:
  - ex_kill in the issue cycle suppresses md_start and md_op; no state change.
  - ex_kill after issue has no effect; the unit cannot abort, so the count runs out.
  - mfhi/mflo need no action from this block; they only stall via id_md_valid.
  - go with op 0xx or 10x while state!=IDLE is not issued and sets proto_err. The hazard unit should make this impossible.
  - Back-to-back: a mult in E with an md op in D gives stall=1 in that same cycle through md_start.
  - Asynchronous reset mid-operation returns to IDLE immediately; the md unit is reset by the same signal.
  - stall_cnt saturates at 16'hFFFF.

Decomposition:
- Shared package md_pkg holds:
  - op localparams OP_MULT..OP_MFLO (000..111);
  - OP_NOP=3'b111 for the idle drive;
  - state encoding IDLE=2'd0, MUL=2'd1, DIV=2'd2.
- No sub-module; the counter is inline. The testbench instantiates md_sched together with the md unit.

Test Plan:
- Reset held low 3 cycles → md_op=111, stall=0, busy=0, stall_cnt=0.
- mult in E, mflo in D at cycle T → md_start=1 at T; stall=1 at T..T+5; stall=0 at T+6; mflo then reads lo of 0x7FFFFFFF*2 = 0xFFFFFFFE.
- div 100/7 with mfhi following → stall for 11 cycles; rd_hi=1 when mfhi is in E; result hi=2, lo=14.
- div in E with ex_kill=1 → md_start=0, busy=0, hi/lo unchanged, stall_cnt unchanged.
- mthi 0x1234 while idle → md_op=100 for one cycle, then 111; unit hi=0x1234; no state change.
- Force mult in E at cycle T+2 after an issued div → no md_start; proto_err=1 and stays 1 until reset. Separately, assert reset low at T+3 of a div → busy=0 asynchronously.
